// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bubble encoding, instruction width, fetch FSM states.
// States are encoded directly as {rsp_v_q, skid_v_q}.
package if_stage_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_ENC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FILL = 2'b00,
    S_RUN  = 2'b10,
    S_HOLD = 2'b01
  } state_t;

endpackage

// File: rtl/if_stage_br_target_calc.sv
// Branch target: PC+4 of the branch plus a signed word offset.
// Pure combinational; wraps modulo 2^32.
module br_target_calc (
  input  logic [31:0] pc4,
  input  logic [15:0] imm16,
  output logic [31:0] target
);

  assign target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, ROM request, 1-entry skid buffer and IF/ID register.
// Optional perf counters when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        br_pc4_i,
  input  logic [15:0]        br_imm16_i,
  output logic               imem_req_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        inst_o,
  output logic [31:0]        pc4_o,
  output logic               valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  logic        rsp_v_q;
  logic        skid_v_q;
  logic [31:0] pc_q;
  logic [31:0] rsp_pc_q;
  logic [31:0] skid_inst_q;
  logic [31:0] skid_pc4_q;
  logic [31:0] target;
  state_t      state;

  assign state       = state_t'({rsp_v_q, skid_v_q});
  assign imem_req_o  = rst_n & (~stall_i | redirect_i);
  assign imem_addr_o = pc_q[IMEM_AW+1:2];

  br_target_calc u_br_target_calc (
    .pc4    (br_pc4_i),
    .imm16  (br_imm16_i),
    .target (target)
  );

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_inst_q <= '0;
      skid_pc4_q  <= '0;
      inst_o      <= NOP_INST;
      pc4_o       <= '0;
      valid_o     <= 1'b0;
    end else if (redirect_i) begin
      // In-flight response belongs to the wrong path
      pc_q     <= target;
      rsp_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      inst_o   <= NOP_INST;
      pc4_o    <= '0;
      valid_o  <= 1'b0;
    end else if (stall_i) begin
      if (state == S_RUN) begin
        skid_inst_q <= imem_rdata_i;
        skid_pc4_q  <= rsp_pc_q + 32'd4;
        skid_v_q    <= 1'b1;
        rsp_v_q     <= 1'b0;
      end
    end else begin
      case (state)
        S_HOLD: begin
          inst_o  <= skid_inst_q;
          pc4_o   <= skid_pc4_q;
          valid_o <= 1'b1;
        end
        S_RUN: begin
          inst_o  <= imem_rdata_i;
          pc4_o   <= rsp_pc_q + 32'd4;
          valid_o <= 1'b1;
        end
        default: begin
          inst_o  <= NOP_INST;
          pc4_o   <= '0;
          valid_o <= 1'b0;
        end
      endcase
      skid_v_q <= 1'b0;
      rsp_v_q  <= 1'b1;
      rsp_pc_q <= pc_q;
      pc_q     <= pc_q + 32'd4;
    end
  end

  a_no_illegal_state: assert property (
    @(negedge clk) !(rsp_v_q && skid_v_q)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (redirect_i)
        flush_cnt_o <= flush_cnt_o + 32'd1;
      if (stall_i && !redirect_i)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (!stall_i && !redirect_i && state != S_FILL)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end
`endif

endmodule
